// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: arbitrates N active-low request lines into one valid/ack grant held in service until eoi.
// Latency: request pin to irq_vld is 2 cycles; next grant at the earliest 1 cycle after eoi.
// Backpressure: the grant waits for ack, dropped on withdrawal or after ACK_TO cycles; ROUND_ROBIN_EN selects rotating priority.
module irq_prio_ctrl #(
   parameter int N      = 9,
   parameter int IDW    = 4,
   parameter int ACK_TO = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req_n,
   input  logic [N-1:0]   mask,
   input  logic           ack,
   input  logic           eoi,
   output logic           irq_vld,
   output logic [IDW-1:0] irq_id,
   output logic [IDW-1:0] irq_id_n,
   output logic           busy,
   output logic           to_err
);

   localparam int CW = $clog2(ACK_TO) + 1;

   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t         state;
   logic [N-1:0]   pend;
   logic [CW-1:0]  cnt;
   logic [IDW-1:0] win_id;
   logic           pend_granted;

   always_comb begin
      pend_granted = 1'b0;
      for (int i = 0; i < N; i++)
         if (irq_id == IDW'(i + 1)) pend_granted = pend[i];
   end

`ifdef ROUND_ROBIN_EN
   logic [IDW-1:0] ptr;
   int             start_line;
   int             dist;
   int             best;

   // Downward distance from the start line picks the winner; ptr itself is searched last.
   always_comb begin
      win_id     = '0;
      best       = N;
      dist       = 0;
      start_line = (ptr <= IDW'(1)) ? N : int'(ptr) - 1;
      for (int i = 0; i < N; i++) begin
         dist = (start_line - (i + 1) + N) % N;
         if (pend[i] && dist < best) begin
            best   = dist;
            win_id = IDW'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (state == REQ && ack)
         ptr <= irq_id;
   end
`else
   always_comb begin
      win_id = '0;
      for (int i = 0; i < N; i++)
         if (pend[i]) win_id = IDW'(i + 1);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pend     <= '0;
         cnt      <= '0;
         irq_vld  <= 1'b0;
         irq_id   <= '0;
         irq_id_n <= '1;
         busy     <= 1'b0;
         to_err   <= 1'b0;
      end else begin
         pend <= ~req_n & mask;
         case (state)
            IDLE: begin
               if (pend != '0) begin
                  irq_id   <= win_id;
                  irq_id_n <= ~win_id;
                  irq_vld  <= 1'b1;
                  cnt      <= '0;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (ack) begin
                  irq_vld <= 1'b0;
                  busy    <= 1'b1;
                  state   <= SERV;
               end else if (!pend_granted) begin
                  irq_vld  <= 1'b0;
                  irq_id   <= '0;
                  irq_id_n <= '1;
                  state    <= IDLE;
               end else if (cnt == CW'(ACK_TO - 1)) begin
                  irq_vld  <= 1'b0;
                  irq_id   <= '0;
                  irq_id_n <= '1;
                  to_err   <= 1'b1;
                  state    <= IDLE;
               end else if (cnt != '1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            SERV: begin
               if (eoi) begin
                  busy     <= 1'b0;
                  irq_id   <= '0;
                  irq_id_n <= '1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: expected grant codes are queued as requests are driven and popped on each irq_vld.
module tb_irq_prio_ctrl;

   localparam int N   = 9;
   localparam int IDW = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_n;
   logic [N-1:0]   mask;
   logic           ack;
   logic           eoi;
   logic           irq_vld;
   logic [IDW-1:0] irq_id;
   logic [IDW-1:0] irq_id_n;
   logic           busy;
   logic           to_err;

   int             checks = 0;
   int             errors = 0;
   logic [IDW-1:0] exp_q[$];

   always #5 clk = ~clk;

   irq_prio_ctrl #(.N(N), .IDW(IDW), .ACK_TO(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_n(req_n), .mask(mask), .ack(ack), .eoi(eoi),
      .irq_vld(irq_vld), .irq_id(irq_id), .irq_id_n(irq_id_n), .busy(busy), .to_err(to_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_vld(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (irq_vld) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic pop_grant(input string name, input bit ok);
      logic [IDW-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      checks++;
      if (!ok || irq_id !== e || irq_id_n !== ~e) begin
         errors++;
         $display("FAIL %s: vld=%0b id=%0d id_n=%b, want vld=1 id=%0d id_n=%b", name, irq_vld, irq_id, irq_id_n, e, ~e);
      end
   endtask

   task automatic idle_out();
      ack   = 1'b0;
      eoi   = 1'b0;
      req_n = '1;
      tick();
      tick();
      if (busy) begin
         eoi = 1'b1;
         tick();
         eoi = 1'b0;
      end
      tick();
      tick();
      exp_q.delete();
   endtask

   task automatic test_reset();
      checks++;
      if ({irq_vld, irq_id, irq_id_n, busy, to_err} !== {1'b0, 4'h0, 4'hF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: vld=%0b id=%0d id_n=%b busy=%0b to_err=%0b, want 0 0 1111 0 0", irq_vld, irq_id, irq_id_n, busy, to_err);
      end
   endtask

   task automatic test_fixed();
      bit ok;
      req_n = 9'b011111110;
      exp_q.push_back(4'd9);
      tick();
      checks++;
      if (irq_vld !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: irq_vld=%0b want 0", irq_vld);
      end
      tick();
      checks++;
      if (irq_vld !== 1'b1) begin
         errors++;
         $display("FAIL latency_2cyc: irq_vld=%0b want 1", irq_vld);
      end
      wait_vld(4, ok);
      pop_grant("grant_9", ok);
      checks++;
      if (irq_id_n !== 4'b0110) begin
         errors++;
         $display("FAIL id_n_9: got %b want 0110", irq_id_n);
      end
      ack = 1'b1;
      tick();
      ack   = 1'b0;
      req_n = 9'b111111110;
      checks++;
      if ({busy, irq_vld, irq_id} !== {1'b1, 1'b0, 4'd9}) begin
         errors++;
         $display("FAIL ack_serv: busy=%0b vld=%0b id=%0d want 1 0 9", busy, irq_vld, irq_id);
      end
      tick();
      eoi = 1'b1;
      exp_q.push_back(4'd1);
      tick();
      eoi = 1'b0;
      checks++;
      if ({busy, irq_vld, irq_id} !== {1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL eoi_idle: busy=%0b vld=%0b id=%0d want 0 0 0", busy, irq_vld, irq_id);
      end
      tick();
      pop_grant("regrant_1_after_eoi", irq_vld);
      idle_out();
   endtask

   task automatic test_mask();
      bit seen = 1'b0;
      bit ok;
      mask  = 9'b011111111;
      req_n = 9'b011111111;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (irq_vld) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL masked_line: irq_vld seen=%0b want 0", seen);
      end
      mask = '1;
      exp_q.push_back(4'd9);
      wait_vld(6, ok);
      pop_grant("unmask_grant_9", ok);
      idle_out();
   endtask

   task automatic test_ack_withdraw();
      bit ok;
      req_n = 9'b111011111;
      exp_q.push_back(4'd6);
      wait_vld(6, ok);
      pop_grant("grant_6", ok);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      checks++;
      if ({irq_vld, busy} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL eoi_in_req: vld=%0b busy=%0b want 1 0", irq_vld, busy);
      end
      req_n = '1;
      tick();
      checks++;
      if (irq_vld !== 1'b1) begin
         errors++;
         $display("FAIL pre_ack_vld: irq_vld=%0b want 1", irq_vld);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if ({busy, irq_vld, to_err, irq_id} !== {1'b1, 1'b0, 1'b0, 4'd6}) begin
         errors++;
         $display("FAIL ack_beats_withdraw: busy=%0b vld=%0b to_err=%0b id=%0d want 1 0 0 6", busy, irq_vld, to_err, irq_id);
      end
      idle_out();
   endtask

   task automatic test_spurious();
      bit ok;
      req_n = 9'b111111011;
      exp_q.push_back(4'd3);
      wait_vld(6, ok);
      pop_grant("grant_3", ok);
      req_n = '1;
      tick();
      tick();
      checks++;
      if ({irq_vld, irq_id, irq_id_n, busy, to_err} !== {1'b0, 4'd0, 4'hF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL withdraw: vld=%0b id=%0d id_n=%b busy=%0b to_err=%0b want 0 0 1111 0 0", irq_vld, irq_id, irq_id_n, busy, to_err);
      end
      idle_out();
   endtask

   task automatic test_order();
      bit ok;
      logic [IDW-1:0] got;
`ifdef ROUND_ROBIN_EN
      localparam int NG = 4;
      localparam bit REL = 1'b0;
      exp_q.push_back(4'd9);
      exp_q.push_back(4'd5);
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd9);
`else
      localparam int NG = 3;
      localparam bit REL = 1'b1;
      exp_q.push_back(4'd9);
      exp_q.push_back(4'd5);
      exp_q.push_back(4'd2);
`endif
      req_n = 9'b011101101;
      for (int k = 0; k < NG; k++) begin
         wait_vld(8, ok);
         got = irq_id;
         pop_grant("order_grant", ok);
         ack = 1'b1;
         tick();
         ack = 1'b0;
         if (REL && got != 0) req_n[got-1] = 1'b1;
         tick();
         eoi = 1'b1;
         tick();
         eoi = 1'b0;
      end
      idle_out();
   endtask

   task automatic test_timeout();
      bit ok;
      int cyc = 0;
      checks++;
      if (to_err !== 1'b0) begin
         errors++;
         $display("FAIL to_err_pre: got %0b want 0", to_err);
      end
      req_n = 9'b111110111;
      exp_q.push_back(4'd4);
      wait_vld(6, ok);
      pop_grant("grant_4", ok);
      while (irq_vld && cyc < 40) begin
         cyc++;
         tick();
      end
      checks++;
      if (cyc != 16) begin
         errors++;
         $display("FAIL timeout_len: irq_vld high %0d cycles want 16", cyc);
      end
      checks++;
      if ({to_err, irq_id, irq_id_n} !== {1'b1, 4'd0, 4'hF}) begin
         errors++;
         $display("FAIL timeout_flag: to_err=%0b id=%0d id_n=%b want 1 0 1111", to_err, irq_id, irq_id_n);
      end
      exp_q.push_back(4'd4);
      wait_vld(4, ok);
      pop_grant("regrant_4", ok);
      idle_out();
      checks++;
      if (to_err !== 1'b1) begin
         errors++;
         $display("FAIL to_err_sticky: got %0b want 1", to_err);
      end
   endtask

   task automatic test_reset_mid_serv();
      bit ok;
      req_n = 9'b110111111;
      exp_q.push_back(4'd7);
      wait_vld(6, ok);
      pop_grant("grant_7", ok);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_before_reset: got %0b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({irq_vld, irq_id, irq_id_n, busy, to_err} !== {1'b0, 4'h0, 4'hF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_serv: vld=%0b id=%0d id_n=%b busy=%0b to_err=%0b want 0 0 1111 0 0", irq_vld, irq_id, irq_id_n, busy, to_err);
      end
      req_n = '1;
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if ({irq_vld, busy} !== {1'b0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_idle: vld=%0b busy=%0b want 0 0", irq_vld, busy);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_n = '1;
      mask  = '1;
      ack   = 1'b0;
      eoi   = 1'b0;
      #22;
      test_reset();
      rst_n = 1'b1;
      tick();
      test_fixed();
      test_mask();
      test_ack_withdraw();
      test_spurious();
      test_order();
      test_timeout();
      test_reset_mid_serv();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
